// File: rtl/cobra_bus_arbiter.sv
// cobra_bus_arbiter: Cobra-1 memory/IO bus controller.
// It handles reset-time address relocation and ROM > VRAM > RAM region decode.
// It also arbitrates the single VRAM port between the CPU and the video fetcher.
// A CPU access can lose to video at most MAX_STALL times before it is served.
module cobra_bus_arbiter #(
  parameter logic [15:0] ROM_BASE   = 16'hC000,
  parameter int          ROM_AW     = 11,
  parameter logic [15:0] VRAM_BASE  = 16'hF800,
  parameter int          VRAM_AW    = 11,
  parameter logic [15:0] RELOC_MASK = 16'hC000,
  parameter logic [7:0]  RELOC_PORT = 8'h1F,
  parameter bit          REARM_EN   = 1'b0,
  parameter int          MAX_STALL  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        cpu_a,
  input  logic [7:0]         cpu_do,
  input  logic               cpu_mreq_n,
  input  logic               cpu_iorq_n,
  input  logic               cpu_rd_n,
  input  logic               cpu_wr_n,
  output logic [7:0]         cpu_di,
  output logic               cpu_wait_n,
  input  logic [7:0]         io_di,
  output logic               reloc_active,
  output logic [15:0]        ram_a,
  output logic [7:0]         ram_do,
  output logic               ram_w,
  input  logic [7:0]         ram_di,
  output logic [ROM_AW-1:0]  rom_a,
  input  logic [7:0]         rom_di,
  output logic [VRAM_AW-1:0] vram_a,
  output logic [7:0]         vram_do,
  output logic               vram_w,
  input  logic [7:0]         vram_di,
  input  logic               vid_req,
  input  logic [VRAM_AW-1:0] vid_a,
  output logic               vid_ack,
  output logic [7:0]         vid_data
);

  localparam int             SW           = $clog2(MAX_STALL + 1);
  localparam logic [SW-1:0]  STALL_MAX_C  = SW'(MAX_STALL);
  localparam logic [7:0]     REARM_PORT_C = RELOC_PORT + 8'd1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VID    = 3'd1,
    ST_CPU_RD = 3'd2,
    ST_CPU_WR = 3'd3,
    ST_HOLD   = 3'd4
  } vram_state_t;

  vram_state_t      state_r, state_s;
  logic             reloc_r;
  logic             done_r;
  logic [SW-1:0]    stall_r;
  logic [7:0]       rbuf_r;

  logic [15:0]      ea_s;
  logic             rom_hit_s, vram_hit_s, vram_sel_s;
  logic             cpu_pend_s, stall_max_s;
  logic             vid_grant_s, cpu_grant_s;
  logic             cpu_wr_s, io_wr_s;

  assign ea_s        = reloc_r ? (cpu_a | RELOC_MASK) : cpu_a;
  assign rom_hit_s   = (ea_s[15:ROM_AW] == ROM_BASE[15:ROM_AW]);
  assign vram_hit_s  = (ea_s[15:VRAM_AW] == VRAM_BASE[15:VRAM_AW]);
  assign vram_sel_s  = vram_hit_s & ~rom_hit_s;
  assign cpu_pend_s  = ~cpu_mreq_n & vram_sel_s & ~done_r;
  assign stall_max_s = (stall_r == STALL_MAX_C);
  // A write grant needs an asserted write strobe with no read strobe alongside it.
  assign cpu_wr_s    = ~cpu_wr_n & cpu_rd_n;
  assign io_wr_s     = ~cpu_iorq_n & ~cpu_wr_n;

  assign reloc_active = reloc_r;
  assign cpu_wait_n   = ~cpu_pend_s;
  assign ram_a        = ea_s;
  assign ram_do       = cpu_do;
  assign ram_w        = ~cpu_mreq_n & ~cpu_wr_n & ~rom_hit_s & ~vram_hit_s;
  assign rom_a        = cpu_a[ROM_AW-1:0];
  assign vid_data     = vram_di;

  // Decide who owns the VRAM port this cycle; video wins unless the CPU has hit its stall limit.
  always_comb begin
    vid_grant_s = 1'b0;
    cpu_grant_s = 1'b0;
    if (rst) begin
      vid_grant_s = 1'b0;
      cpu_grant_s = 1'b0;
    end else if (vid_req && !(cpu_pend_s && stall_max_s)) begin
      vid_grant_s = 1'b1;
    end else if (cpu_pend_s) begin
      cpu_grant_s = 1'b1;
    end else begin
      vid_grant_s = 1'b0;
      cpu_grant_s = 1'b0;
    end
  end

  // VRAM arbitration state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_s;
  end

  // Next state: every state accepts new grants; otherwise park in HOLD while the CPU cycle is open.
  always_comb begin
    state_s = ST_IDLE;
    if (vid_grant_s) begin
      state_s = ST_VID;
    end else if (cpu_grant_s) begin
      state_s = cpu_wr_s ? ST_CPU_WR : ST_CPU_RD;
    end else if (done_r && !cpu_mreq_n) begin
      state_s = ST_HOLD;
    end else begin
      state_s = ST_IDLE;
    end
  end

  // VRAM port and video acknowledge outputs.
  always_comb begin
    vid_ack = 1'b0;
    vram_a  = ea_s[VRAM_AW-1:0];
    vram_w  = 1'b0;
    vram_do = 8'h00;
    case (state_r)
      ST_VID:  vid_ack = 1'b1;
      default: vid_ack = 1'b0;
    endcase
    if (vid_grant_s) begin
      vram_a = vid_a;
    end else if (cpu_grant_s) begin
      vram_a  = ea_s[VRAM_AW-1:0];
      vram_w  = cpu_wr_s;
      vram_do = cpu_wr_s ? cpu_do : 8'h00;
    end else begin
      vram_a = ea_s[VRAM_AW-1:0];
    end
  end

  // CPU read data mux; the VRAM buffer is bypassed on the cycle the read data arrives.
  always_comb begin
    cpu_di = ram_di;
    if (cpu_mreq_n) begin
      cpu_di = io_di;
    end else if (rom_hit_s) begin
      cpu_di = rom_di;
    end else if (vram_sel_s) begin
      cpu_di = (state_r == ST_CPU_RD) ? vram_di : rbuf_r;
    end else begin
      cpu_di = ram_di;
    end
  end

  // Relocation flag: set by reset, cleared by an OUT to RELOC_PORT, optionally re-armed by RELOC_PORT+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      reloc_r <= 1'b1;
    end else if (io_wr_s && (cpu_a[7:0] == RELOC_PORT)) begin
      reloc_r <= 1'b0;
    end else if (REARM_EN && io_wr_s && (cpu_a[7:0] == REARM_PORT_C)) begin
      reloc_r <= 1'b1;
    end else begin
      reloc_r <= reloc_r;
    end
  end

  // One VRAM operation per CPU memory cycle: done is set on grant and released when MREQ goes high.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_r <= 1'b0;
    end else if (cpu_mreq_n) begin
      done_r <= 1'b0;
    end else if (cpu_grant_s) begin
      done_r <= 1'b1;
    end else begin
      done_r <= done_r;
    end
  end

  // Count cycles a pending CPU access loses to video, saturating at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_r <= '0;
    end else if (cpu_grant_s) begin
      stall_r <= '0;
    end else if (vid_grant_s && cpu_pend_s && !stall_max_s) begin
      stall_r <= stall_r + SW'(1);
    end else begin
      stall_r <= stall_r;
    end
  end

  // Capture CPU VRAM read data one cycle after the read grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rbuf_r <= 8'h00;
    end else if (state_r == ST_CPU_RD) begin
      rbuf_r <= vram_di;
    end else begin
      rbuf_r <= rbuf_r;
    end
  end

endmodule

// File: tb/tb_cobra_bus_arbiter.sv
// Directed bench for cobra_bus_arbiter with a cycle-level reference model of the bus rules.
module tb_cobra_bus_arbiter;

  localparam int MAX_STALL = 4;

  logic        clk;
  logic        rst;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_do;
  logic        cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n;
  logic [7:0]  cpu_di;
  logic        cpu_wait_n;
  logic [7:0]  io_di;
  logic        reloc_active;
  logic [15:0] ram_a;
  logic [7:0]  ram_do;
  logic        ram_w;
  logic [7:0]  ram_di;
  logic [10:0] rom_a;
  logic [7:0]  rom_di;
  logic [10:0] vram_a;
  logic [7:0]  vram_do;
  logic        vram_w;
  logic [7:0]  vram_di;
  logic        vid_req;
  logic [10:0] vid_a;
  logic        vid_ack;
  logic [7:0]  vid_data;

  int n_checks = 0;
  int n_errors = 0;

  cobra_bus_arbiter #(.REARM_EN(1'b1), .MAX_STALL(MAX_STALL)) dut (
    .clk(clk), .rst(rst), .cpu_a(cpu_a), .cpu_do(cpu_do),
    .cpu_mreq_n(cpu_mreq_n), .cpu_iorq_n(cpu_iorq_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
    .cpu_di(cpu_di), .cpu_wait_n(cpu_wait_n), .io_di(io_di), .reloc_active(reloc_active),
    .ram_a(ram_a), .ram_do(ram_do), .ram_w(ram_w), .ram_di(ram_di),
    .rom_a(rom_a), .rom_di(rom_di),
    .vram_a(vram_a), .vram_do(vram_do), .vram_w(vram_w), .vram_di(vram_di),
    .vid_req(vid_req), .vid_a(vid_a), .vid_ack(vid_ack), .vid_data(vid_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous VRAM: read-before-write, one cycle latency.
  logic [7:0] vmem [0:2047];
  always @(posedge clk) begin
    if (vram_w === 1'b1) vmem[vram_a] <= vram_do;
    vram_di <= vmem[vram_a];
  end

  // Reference model state (current and next).
  logic       m_reloc, m_done, m_ack;
  int         m_stall;
  logic [7:0] m_vdat, m_buf;
  logic       nx_reloc, nx_done, nx_ack;
  int         nx_stall;
  logic [7:0] nx_vdat, nx_buf;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Evaluate the bus rules for the current cycle and compare every meaningful output.
  task automatic model_step();
    logic [15:0] ea;
    logic        rom, vr, mreq, wr, pend, vg, cg;
    logic [7:0]  exp_di;
    if (rst) begin
      nx_reloc = 1'b1; nx_done = 1'b0; nx_stall = 0;
      nx_ack = 1'b0; nx_vdat = 8'h00; nx_buf = 8'h00;
    end else begin
      ea   = m_reloc ? (cpu_a | 16'hC000) : cpu_a;
      rom  = (ea >= 16'hC000) && (ea < 16'hC800);
      vr   = !rom && (ea >= 16'hF800);
      mreq = !cpu_mreq_n;
      wr   = !cpu_wr_n;
      pend = mreq && vr && !m_done;
      vg   = vid_req && !(pend && (m_stall == MAX_STALL));
      cg   = !vg && pend;
      if (!mreq)     exp_di = io_di;
      else if (rom)  exp_di = rom_di;
      else if (vr)   exp_di = m_buf;
      else           exp_di = ram_di;

      chk("m_reloc",  {15'h0, reloc_active}, {15'h0, m_reloc});
      chk("m_ram_a",  ram_a, ea);
      chk("m_ram_do", {8'h0, ram_do}, {8'h0, cpu_do});
      chk("m_rom_a",  {5'h0, rom_a}, cpu_a & 16'h07FF);
      chk("m_ram_w",  {15'h0, ram_w}, {15'h0, (mreq && wr && !rom && !vr)});
      chk("m_wait_n", {15'h0, cpu_wait_n}, {15'h0, !pend});
      chk("m_vram_w", {15'h0, vram_w}, {15'h0, (cg && wr)});
      chk("m_vid_ack", {15'h0, vid_ack}, {15'h0, m_ack});
      chk("m_cpu_di", {8'h0, cpu_di}, {8'h0, exp_di});
      if (m_ack) chk("m_vid_data", {8'h0, vid_data}, {8'h0, m_vdat});
      if (vg) chk("m_vram_a_vid", {5'h0, vram_a}, {5'h0, vid_a});
      if (cg) chk("m_vram_a_cpu", {5'h0, vram_a}, ea & 16'h07FF);
      if (cg && wr) chk("m_vram_do", {8'h0, vram_do}, {8'h0, cpu_do});

      nx_reloc = m_reloc;
      if (!cpu_iorq_n && wr && cpu_a[7:0] == 8'h1F)      nx_reloc = 1'b0;
      else if (!cpu_iorq_n && wr && cpu_a[7:0] == 8'h20) nx_reloc = 1'b1;
      nx_done  = !mreq ? 1'b0 : (cg ? 1'b1 : m_done);
      if (cg) nx_stall = 0;
      else if (vg && pend && m_stall < MAX_STALL) nx_stall = m_stall + 1;
      else nx_stall = m_stall;
      nx_ack  = vg;
      nx_vdat = vmem[vid_a];
      nx_buf  = (cg && !wr) ? vmem[ea[10:0]] : m_buf;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    m_reloc = nx_reloc; m_done = nx_done; m_stall = nx_stall;
    m_ack = nx_ack; m_vdat = nx_vdat; m_buf = nx_buf;
    #1;
  endtask

  task automatic bus(input logic [15:0] a, input logic mq, input logic iq,
                     input logic rd, input logic wr, input logic [7:0] d);
    cpu_a = a; cpu_mreq_n = ~mq; cpu_iorq_n = ~iq; cpu_rd_n = ~rd; cpu_wr_n = ~wr; cpu_do = d;
  endtask

  task automatic idle();
    bus(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    bus(a, 1'b1, 1'b0, 1'b0, 1'b1, d);
    tick(); tick();
    idle();
    tick();
  endtask

  int waits, acks;

  initial begin
    m_reloc = 1'b1; m_done = 1'b0; m_stall = 0; m_ack = 1'b0; m_vdat = 8'h00; m_buf = 8'h00;
    rst = 1'b1; vid_req = 1'b0; vid_a = 11'h000;
    rom_di = 8'hA5; ram_di = 8'h3C; io_di = 8'h77;
    idle();
    tick(); tick();
    rst = 1'b0;
    #2;
    chk("rst_reloc", {15'h0, reloc_active}, 16'h0001);
    chk("rst_wait_n", {15'h0, cpu_wait_n}, 16'h0001);
    chk("rst_vid_ack", {15'h0, vid_ack}, 16'h0000);
    chk("rst_vram_w", {15'h0, vram_w}, 16'h0000);

    // Relocated fetch from 0000 hits ROM at C000.
    bus(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    #2;
    chk("fetch_rom_di", {8'h0, cpu_di}, 16'h00A5);
    chk("fetch_ea", ram_a, 16'hC000);
    tick();
    idle(); #2;
    chk("io_read", {8'h0, cpu_di}, 16'h0077);
    tick();

    // OUT to 1F clears relocation for the following bus cycle.
    bus(16'h001F, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    tick();
    idle(); #2;
    chk("reloc_cleared", {15'h0, reloc_active}, 16'h0000);
    bus(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00); #2;
    chk("ram_read", {8'h0, cpu_di}, 16'h003C);
    tick();

    // Re-arm with OUT to 20, then clear again.
    bus(16'h0020, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00); #2;
    chk("rearm_pre", {15'h0, reloc_active}, 16'h0000);
    tick();
    idle(); #2;
    chk("rearm_post", {15'h0, reloc_active}, 16'h0001);
    tick();
    bus(16'h001F, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    tick();
    idle(); tick();

    // VRAM write with video idle: one wait cycle, single vram_w.
    bus(16'hF805, 1'b1, 1'b0, 1'b0, 1'b1, 8'h41); #2;
    chk("vw_w", {15'h0, vram_w}, 16'h0001);
    chk("vw_a", {5'h0, vram_a}, 16'h0005);
    chk("vw_do", {8'h0, vram_do}, 16'h0041);
    chk("vw_wait", {15'h0, cpu_wait_n}, 16'h0000);
    tick(); #2;
    chk("vw_w_off", {15'h0, vram_w}, 16'h0000);
    chk("vw_wait_off", {15'h0, cpu_wait_n}, 16'h0001);
    tick();
    idle(); tick();

    // Read back F805.
    bus(16'hF805, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00); #2;
    chk("vr_wait", {15'h0, cpu_wait_n}, 16'h0000);
    tick(); #2;
    chk("vr_data", {8'h0, cpu_di}, 16'h0041);
    chk("vr_wait_off", {15'h0, cpu_wait_n}, 16'h0001);
    tick();
    idle(); tick();

    // Writes to ROM are dropped.
    bus(16'hC010, 1'b1, 1'b0, 1'b0, 1'b1, 8'h99); #2;
    chk("romw_ram_w", {15'h0, ram_w}, 16'h0000);
    chk("romw_vram_w", {15'h0, vram_w}, 16'h0000);
    tick(); tick();
    idle(); tick();

    // Plain RAM write.
    bus(16'h1234, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5E); #2;
    chk("ramw_w", {15'h0, ram_w}, 16'h0001);
    tick();
    idle(); tick();

    cpu_write(16'hF800, 8'h5A);
    cpu_write(16'hF810, 8'hC3);
    cpu_write(16'hF801, 8'h11);

    // Single video fetch.
    vid_a = 11'h010; vid_req = 1'b1; #2;
    chk("vid_ack_pre", {15'h0, vid_ack}, 16'h0000);
    tick(); #2;
    chk("vid_ack", {15'h0, vid_ack}, 16'h0001);
    chk("vid_data", {8'h0, vid_data}, 16'h00C3);
    vid_req = 1'b0;
    tick(); #2;
    chk("vid_ack_once", {15'h0, vid_ack}, 16'h0000);
    tick();

    // Continuous video plus CPU read: CPU served after MAX_STALL losses.
    vid_req = 1'b1;
    bus(16'hF800, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    waits = 0; acks = 0;
    for (int i = 0; i < 10; i++) begin
      #2;
      if (!cpu_wait_n) begin
        waits++;
        if (vid_ack) acks++;
      end
      tick();
    end
    #1;
    chk("stall_waits", 16'(waits), 16'd5);
    chk("stall_acks", 16'(acks), 16'd4);
    chk("stall_data", {8'h0, cpu_di}, 16'h005A);
    vid_req = 1'b0; idle();
    tick(); tick();

    // Reset while a CPU VRAM write is pending behind video.
    vid_req = 1'b1;
    bus(16'hF801, 1'b1, 1'b0, 1'b0, 1'b1, 8'hEE);
    tick(); tick(); #2;
    chk("pend_wait", {15'h0, cpu_wait_n}, 16'h0000);
    rst = 1'b1; vid_req = 1'b0; idle();
    tick();
    rst = 1'b0; #2;
    chk("rstw_vram_w", {15'h0, vram_w}, 16'h0000);
    chk("rstw_vid_ack", {15'h0, vid_ack}, 16'h0000);
    chk("rstw_wait_n", {15'h0, cpu_wait_n}, 16'h0001);
    chk("rstw_reloc", {15'h0, reloc_active}, 16'h0001);
    tick();
    bus(16'hF801, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    tick(); #2;
    chk("rstw_unwritten", {8'h0, cpu_di}, 16'h0011);
    tick();
    idle(); tick();

    // Region boundaries under relocation.
    bus(16'h07FF, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00); #2;
    chk("bnd_rom_top", {8'h0, cpu_di}, 16'h00A5);
    tick();
    bus(16'h0800, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00); #2;
    chk("bnd_ram_c800", {8'h0, cpu_di}, 16'h003C);
    tick();
    bus(16'h37FF, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00); #2;
    chk("bnd_ram_f7ff", {8'h0, cpu_di}, 16'h003C);
    tick();
    idle(); tick();

    // Reset during a video grant.
    vid_a = 11'h010; vid_req = 1'b1;
    tick();
    rst = 1'b1; vid_req = 1'b0;
    tick();
    rst = 1'b0; #2;
    chk("rstv_vid_ack", {15'h0, vid_ack}, 16'h0000);
    chk("rstv_vram_w", {15'h0, vram_w}, 16'h0000);
    chk("rstv_wait_n", {15'h0, cpu_wait_n}, 16'h0001);
    chk("rstv_reloc", {15'h0, reloc_active}, 16'h0001);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
